logic_8_bist: RTL and testbench

LOGIC_8_BIST -- requirements
Module: logic_8_bist

---
 rtl/logic_8_bist.sv | 193 +++++++++++++++++++
 tb/tb_logic_8_bist.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_8_bist.sv
// Built-in self-test sequencer for an 8-bit logic unit.
// Drives LFSR-generated operand pairs through opcodes 000..101, compares
// the returned result against a reference and records the first failure.
module logic_8_bist #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] seed,
    input  logic [7:0] num_vectors,
    output logic [7:0] dut_a,
    output logic [7:0] dut_b,
    output logic [2:0] dut_op,
    input  logic [7:0] dut_result,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [2:0] fail_op,
    output logic [7:0] fail_a,
    output logic [7:0] fail_b,
    output logic [7:0] fail_result
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] OP_LAST     = 3'b101;

    state_t     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] idx_q, idx_d;
    logic [8:0] n_q, n_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [2:0] op_q, op_d;
    logic [7:0] err_q, err_d;
    logic [2:0] fop_q, fop_d;
    logic [7:0] fa_q, fa_d;
    logic [7:0] fb_q, fb_d;
    logic [7:0] fr_q, fr_d;

    logic [7:0] expected;
    logic       mismatch;
    logic [7:0] a_step, b_step;
    logic [8:0] n_last;

    // Reference model of the logic unit for the opcode currently driven
    always_comb begin
        expected = '0;
        case (op_q)
            3'b000:  expected = ~a_q;
            3'b001:  expected = a_q & b_q;
            3'b010:  expected = a_q | b_q;
            3'b011:  expected = ~(a_q & b_q);
            3'b100:  expected = {a_q[6:0], a_q[7]};
            3'b101:  expected = {a_q[0], a_q[7:1]};
            default: expected = '0;
        endcase
    end

    // LFSR next values and end-of-opcode bound
    always_comb begin
        a_step   = {a_q[6:0], a_q[7] ^ a_q[5] ^ a_q[4] ^ a_q[3]};
        b_step   = {b_q[6:0], b_q[7] ^ b_q[5] ^ b_q[4] ^ b_q[3]};
        n_last   = n_q - 9'd1;
        mismatch = (dut_result != expected);
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            idx_q    <= '0;
            n_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            err_q    <= '0;
            fop_q    <= '0;
            fa_q     <= '0;
            fb_q     <= '0;
            fr_q     <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            err_q    <= err_d;
            fop_q    <= fop_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            fr_q     <= fr_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        n_d      = n_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        err_d    = err_q;
        fop_d    = fop_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        fr_d     = fr_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = APPLY;
                    n_d      = (num_vectors == 8'd0) ? 9'd256 : {1'b0, num_vectors};
                    a_d      = (seed == 8'h00) ? 8'h01 : seed;
                    b_d      = (seed == 8'hFF) ? 8'h01 : ~seed;
                    op_d     = '0;
                    idx_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    fop_d    = '0;
                    fa_d     = '0;
                    fb_d     = '0;
                    fr_d     = '0;
                end
            end

            APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = CHECK;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            CHECK: begin
                if (mismatch) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (err_q == 8'd0) begin
                        fop_d = op_q;
                        fa_d  = a_q;
                        fb_d  = b_q;
                        fr_d  = dut_result;
                    end
                end
                if ({1'b0, idx_q} != n_last) begin
                    a_d     = a_step;
                    b_d     = b_step;
                    idx_d   = idx_q + 8'd1;
                    state_d = APPLY;
                end else if (op_q != OP_LAST) begin
                    a_d     = a_step;
                    b_d     = b_step;
                    idx_d   = '0;
                    op_d    = op_q + 3'd1;
                    state_d = APPLY;
                end else begin
                    state_d = DONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign dut_a       = a_q;
    assign dut_b       = b_q;
    assign dut_op      = op_q;
    assign busy        = (state_q == APPLY) || (state_q == CHECK);
    assign done        = (state_q == DONE);
    assign pass        = done && (err_q == 8'd0);
    assign err_count   = err_q;
    assign fail_op     = fop_q;
    assign fail_a      = fa_q;
    assign fail_b      = fb_q;
    assign fail_result = fr_q;

endmodule

// File: tb/tb_logic_8_bist.sv
// Directed testbench for logic_8_bist with a bench-side logic unit that can
// be switched between correct, NAND bit0 stuck-at-0, and all-zero behaviour.
module tb_logic_8_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic [7:0] num_vectors;
    logic [7:0] dut_a, dut_b;
    logic [2:0] dut_op;
    logic [7:0] dut_result;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [2:0] fail_op;
    logic [7:0] fail_a, fail_b, fail_result;

    int ncmp  = 0;
    int nfail = 0;
    int mode  = 0;
    logic illegal_op = 1'b0;

    logic_8_bist #(.SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .num_vectors(num_vectors), .dut_a(dut_a), .dut_b(dut_b),
        .dut_op(dut_op), .dut_result(dut_result), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .fail_op(fail_op),
        .fail_a(fail_a), .fail_b(fail_b), .fail_result(fail_result)
    );

    always #5 clk = ~clk;

    // Logic unit under test
    always_comb begin
        case (dut_op)
            3'b000:  dut_result = ~dut_a;
            3'b001:  dut_result = dut_a & dut_b;
            3'b010:  dut_result = dut_a | dut_b;
            3'b011:  dut_result = ~(dut_a & dut_b);
            3'b100:  dut_result = {dut_a[6:0], dut_a[7]};
            3'b101:  dut_result = {dut_a[0], dut_a[7:1]};
            default: dut_result = 8'h00;
        endcase
        if (mode == 1 && dut_op == 3'b011) dut_result[0] = 1'b0;
        if (mode == 2) dut_result = 8'h00;
    end

    always @(negedge clk) if (dut_op > 3'd5) illegal_op = 1'b1;

    function automatic logic [7:0] lfsr(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns in the first APPLY cycle
    task automatic pulse_start(input logic [7:0] s, input logic [7:0] n);
        seed = s;
        num_vectors = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count cycles from t+1 until done (cyc = offset from start cycle)
    task automatic wait_done(input int limit, output int cyc, output int busy_cyc);
        cyc = 1;
        busy_cyc = 0;
        while (done !== 1'b1 && cyc < limit) begin
            if (busy === 1'b1) busy_cyc++;
            tick();
            cyc++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_dut_a"}, dut_a, 0);
        chk({tag, "_dut_b"}, dut_b, 0);
        chk({tag, "_dut_op"}, dut_op, 0);
        chk({tag, "_fail"}, {fail_op, fail_a, fail_b, fail_result}, 0);
    endtask

    initial begin : stim
        int cyc, bcyc, k;
        logic [7:0] ma, mb, nand_v, ffa, ffb;
        int exp_err;
        logic got_first;

        rst = 1'b1; start = 1'b0; seed = '0; num_vectors = '0;
        tick(); tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // Correct unit, seed A5, N=4
        mode = 0;
        pulse_start(8'hA5, 8'd4);
        chk("r34_first_a", dut_a, 8'hA5);
        chk("r34_first_b", dut_b, 8'h5A);
        chk("r34_first_op", dut_op, 3'b000);
        wait_done(200, cyc, bcyc);
        chk("r34_latency", cyc, 49);
        chk("r34_busy_cycles", bcyc, 48);
        chk("r34_pass", pass, 1);
        chk("r34_err", err_count, 0);
        chk("r34_fail", {fail_op, fail_a, fail_b, fail_result}, 0);
        tick(); tick();
        chk("r34_hold_done", done, 1);
        chk("r34_hold_op", dut_op, 3'b101);

        // Restart from DONE with seed 00, then abort at op 010
        pulse_start(8'h00, 8'd4);
        chk("r36_seed00_a", dut_a, 8'h01);
        chk("r36_seed00_b", dut_b, 8'hFF);
        chk("restart_done_clr", done, 0);
        chk("restart_busy", busy, 1);
        k = 0;
        while (dut_op !== 3'b010 && k < 200) begin tick(); k++; end
        chk("r37_reach_op2", dut_op, 3'b010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("r37_abort");

        // Reset wins over a simultaneous start
        rst = 1'b1; seed = 8'h77; num_vectors = 8'd4; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", busy, 0);
        chk("rst_prio_a", dut_a, 0);

        // Seed FF, full correct run after the abort
        pulse_start(8'hFF, 8'd4);
        chk("r36_seedFF_a", dut_a, 8'hFF);
        chk("r36_seedFF_b", dut_b, 8'h01);
        wait_done(200, cyc, bcyc);
        chk("r37_rerun_latency", cyc, 49);
        chk("r37_rerun_pass", pass, 1);

        // NAND bit0 stuck at 0, N=8, seed 3C
        ma = 8'h3C; mb = 8'hC3;
        for (int v = 0; v < 24; v++) begin ma = lfsr(ma); mb = lfsr(mb); end
        exp_err = 0; got_first = 1'b0; ffa = '0; ffb = '0;
        for (int i = 0; i < 8; i++) begin
            nand_v = ~(ma & mb);
            if (nand_v[0]) begin
                exp_err++;
                if (!got_first) begin ffa = ma; ffb = mb; got_first = 1'b1; end
            end
            ma = lfsr(ma); mb = lfsr(mb);
        end
        mode = 1;
        pulse_start(8'h3C, 8'd8);
        wait_done(400, cyc, bcyc);
        chk("r35_latency", cyc, 97);
        chk("r35_pass", pass, 0);
        chk("r35_err", err_count, exp_err);
        chk("r35_fail_op", fail_op, 3'b011);
        chk("r35_fail_a", fail_a, ffa);
        chk("r35_fail_b", fail_b, ffb);
        chk("r35_fail_result", fail_result, ~(ffa & ffb) & 8'hFE);

        // All-zero unit, N=0 (256), extra start while busy
        mode = 2;
        pulse_start(8'h12, 8'd0);
        for (int i = 0; i < 8; i++) tick();
        seed = 8'h99; num_vectors = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("r38_busy_ignores_start", busy, 1);
        cyc = 10;
        while (done !== 1'b1 && cyc < 5000) begin tick(); cyc++; end
        chk("r38_latency", cyc, 3073);
        chk("r38_err_sat", err_count, 8'hFF);
        chk("r38_pass", pass, 0);
        chk("r38_fail_op", fail_op, 3'b000);
        chk("r38_fail_a", fail_a, 8'h12);
        chk("r38_fail_b", fail_b, 8'hED);
        chk("r38_fail_result", fail_result, 8'h00);

        chk("no_illegal_op", illegal_op, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
